decrypter_out: RTL and testbench

Unpacks decrypted plaintext words from FastModExp into a byte stream for the UART transmitter; the inverse of the packing done on the encryption side. Each FastModExp result carries k = n_len − 1 valid plaintext bits, right-aligned in a 32-bit word and consumed LSB-first. The bits are reassembled into bytes, LSB-first, and each completed byte is sent through the UART tx_start/tx_done_tick handshake. The block sits between the decryption FastModExp instance and the Crypter transmit multiplexer.

---
 rtl/decrypter_out.sv | 119 +++++++++++
 tb/tb_decrypter_out.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decrypter_out.sv
// rtl/decrypter_out.sv - unpacks k-bit plaintext words from FastModExp into an LSB-first UART byte stream
// Bytes may straddle words; the partial byte survives between words until start or reset.
module decrypter_out (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  n_len,
   input  logic        word_ready,
   input  logic [31:0] data_in,
   input  logic        tx_done_tick,
   output logic        tx_start,
   output logic [7:0]  data_out,
   output logic        busy,
   output logic        overrun,
   output logic [2:0]  pending_bits
);

   typedef enum logic [1:0] {IDLE, SHIFT, SEND, WAIT} state_t;

   state_t      state_q, state_d;
   logic [31:0] word_reg_q, word_reg_d;
   logic [7:0]  byte_buf_q, byte_buf_d;
   logic [5:0]  bits_left_q, bits_left_d;
   logic [3:0]  byte_cnt_q, byte_cnt_d;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        overrun_q, overrun_d;
   logic [5:0]  k;

   // Plaintext bits per word; a key wider than the datapath still yields at most 31 bits.
   always_comb begin
      k = (n_len > 6'd32) ? 6'd31 : (n_len - 6'd1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         word_reg_q  <= '0;
         byte_buf_q  <= '0;
         bits_left_q <= '0;
         byte_cnt_q  <= '0;
         tx_start_q  <= 1'b0;
         data_out_q  <= '0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         word_reg_q  <= word_reg_d;
         byte_buf_q  <= byte_buf_d;
         bits_left_q <= bits_left_d;
         byte_cnt_q  <= byte_cnt_d;
         tx_start_q  <= tx_start_d;
         data_out_q  <= data_out_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      word_reg_d  = word_reg_q;
      byte_buf_d  = byte_buf_q;
      bits_left_d = bits_left_q;
      byte_cnt_d  = byte_cnt_q;
      tx_start_d  = 1'b0;
      data_out_d  = data_out_q;
      overrun_d   = overrun_q;

      if (start) begin
         state_d     = IDLE;
         byte_buf_d  = '0;
         byte_cnt_d  = '0;
         bits_left_d = '0;
         overrun_d   = 1'b0;
      end else begin
         if (word_ready && (state_q != IDLE)) begin
            overrun_d = 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (word_ready && (n_len >= 6'd2)) begin
                  word_reg_d  = data_in;
                  bits_left_d = k;
                  state_d     = SHIFT;
               end
            end
            SHIFT: begin
               byte_buf_d  = {word_reg_q[0], byte_buf_q[7:1]};
               word_reg_d  = word_reg_q >> 1;
               bits_left_d = bits_left_q - 6'd1;
               byte_cnt_d  = byte_cnt_q + 4'd1;
               // Registering the byte here makes tx_start and data_out valid during SEND.
               if (byte_cnt_d == 4'd8) begin
                  state_d    = SEND;
                  data_out_d = byte_buf_d;
                  tx_start_d = 1'b1;
               end else if (bits_left_d == 6'd0) begin
                  state_d = IDLE;
               end
            end
            SEND: begin
               byte_cnt_d = '0;
               state_d    = WAIT;
            end
            WAIT: begin
               if (tx_done_tick) begin
                  state_d = (bits_left_q != 6'd0) ? SHIFT : IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign tx_start     = tx_start_q;
   assign data_out     = data_out_q;
   assign busy         = (state_q != IDLE);
   assign overrun      = overrun_q;
   assign pending_bits = byte_cnt_q[2:0];

endmodule

// File: tb/tb_decrypter_out.sv
// tb/tb_decrypter_out.sv - directed self-checking bench for decrypter_out
module tb_decrypter_out;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  n_len;
   logic        word_ready;
   logic [31:0] data_in;
   logic        tx_done_tick;
   logic        tx_start;
   logic [7:0]  data_out;
   logic        busy;
   logic        overrun;
   logic [2:0]  pending_bits;

   int n_asserts = 0;
   int n_fail    = 0;

   logic       got;
   logic [7:0] b;
   int         cyc;

   decrypter_out dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .n_len        (n_len),
      .word_ready   (word_ready),
      .data_in      (data_in),
      .tx_done_tick (tx_done_tick),
      .tx_start     (tx_start),
      .data_out     (data_out),
      .busy         (busy),
      .overrun      (overrun),
      .pending_bits (pending_bits)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic word(input logic [5:0] nl, input logic [31:0] d);
      n_len      = nl;
      data_in    = d;
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
   endtask

   task automatic done();
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
   endtask

   // cycles counts edges after the word_ready edge until tx_start is seen
   task automatic wait_tx(input int limit, output logic g, output logic [7:0] bv, output int cycles);
      g = 1'b0;
      bv = 8'h00;
      cycles = 0;
      while (!g && cycles < limit) begin
         tick();
         cycles++;
         if (tx_start) begin
            g  = 1'b1;
            bv = data_out;
         end
      end
   endtask

   task automatic wait_idle(input int limit);
      int c;
      c = 0;
      while (busy && c < limit) begin
         tick();
         c++;
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; n_len = '0; word_ready = 1'b0;
      data_in = '0; tx_done_tick = 1'b0;
      repeat (3) tick();
      check("rst_tx_start", tx_start, 0);
      check("rst_data_out", data_out, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_pending", pending_bits, 0);
      rst = 1'b1;
      tick();

      // single full byte, k = 8
      word(6'd9, 32'h41);
      wait_tx(20, got, b, cyc);
      check("t1_got", got, 1);
      check("t1_byte", b, 8'h41);
      check("t1_edges", cyc + 1, 9);
      tick();
      check("t1_pulse_one_cycle", tx_start, 0);
      check("t1_busy_wait", busy, 1);
      done();
      check("t1_busy_after", busy, 0);
      check("t1_pending", pending_bits, 0);

      // n_len below 2 is ignored
      word(6'd1, 32'hFF);
      check("t1b_busy", busy, 0);
      wait_tx(12, got, b, cyc);
      check("t1b_no_tx", got, 0);
      check("t1b_overrun", overrun, 0);

      // two 4-bit words forming one byte
      word(6'd5, 32'h1);
      wait_tx(12, got, b, cyc);
      check("t2_no_tx", got, 0);
      check("t2_busy", busy, 0);
      check("t2_pending4", pending_bits, 4);
      word(6'd5, 32'h4);
      wait_tx(12, got, b, cyc);
      check("t2_got", got, 1);
      check("t2_byte", b, 8'h41);
      check("t2_edges", cyc, 4);
      tick();
      done();
      check("t2_busy_after", busy, 0);
      check("t2_pending0", pending_bits, 0);

      // 12-bit words straddling byte boundaries
      word(6'd13, 32'hABC);
      wait_tx(20, got, b, cyc);
      check("t3_got_a", got, 1);
      check("t3_byte_a", b, 8'hBC);
      check("t3_edges_a", cyc, 8);
      tick();
      done();
      wait_idle(20);
      check("t3_idle_a", busy, 0);
      check("t3_pending4", pending_bits, 4);
      word(6'd13, 32'h000);
      wait_tx(20, got, b, cyc);
      check("t3_got_b", got, 1);
      check("t3_byte_b", b, 8'h0A);
      check("t3_edges_b", cyc, 4);
      tick();
      done();
      wait_tx(20, got, b, cyc);
      check("t3_got_c", got, 1);
      check("t3_byte_c", b, 8'h00);
      check("t3_edges_c", cyc, 8);
      tick();
      done();
      check("t3_busy_after", busy, 0);
      check("t3_pending0", pending_bits, 0);

      // 16-bit word yields two bytes
      word(6'd17, 32'h4241);
      wait_tx(20, got, b, cyc);
      check("t4_got_a", got, 1);
      check("t4_byte_a", b, 8'h41);
      check("t4_edges_a", cyc + 1, 9);
      tick();
      done();
      wait_tx(20, got, b, cyc);
      check("t4_got_b", got, 1);
      check("t4_byte_b", b, 8'h42);
      tick();
      done();
      check("t4_busy_after", busy, 0);

      // overrun while waiting on the UART, then start clears it
      word(6'd9, 32'h55);
      wait_tx(20, got, b, cyc);
      check("t5_byte", b, 8'h55);
      tick();
      word(6'd9, 32'hFF);
      check("t5_overrun", overrun, 1);
      check("t5_busy", busy, 1);
      done();
      check("t5_busy_after", busy, 0);
      check("t5_data_hold", data_out, 8'h55);
      wait_tx(12, got, b, cyc);
      check("t5_no_extra_tx", got, 0);
      check("t5_overrun_sticky", overrun, 1);
      word(6'd5, 32'hF);
      wait_idle(20);
      check("t5_pending4", pending_bits, 4);
      start      = 1'b1;
      n_len      = 6'd9;
      data_in    = 32'h77;
      word_ready = 1'b1;
      tick();
      start      = 1'b0;
      word_ready = 1'b0;
      check("t5_start_overrun", overrun, 0);
      check("t5_start_pending", pending_bits, 0);
      check("t5_start_busy", busy, 0);
      word(6'd9, 32'h12);
      wait_tx(20, got, b, cyc);
      check("t5_clean_byte", b, 8'h12);
      check("t5_clean_edges", cyc, 8);
      tick();
      done();

      // reset in WAIT
      word(6'd9, 32'h33);
      wait_tx(20, got, b, cyc);
      check("t6_byte", b, 8'h33);
      tick();
      rst = 1'b0;
      #1;
      check("t6_tx_start", tx_start, 0);
      check("t6_data_out", data_out, 0);
      check("t6_busy", busy, 0);
      check("t6_overrun", overrun, 0);
      tick();
      rst = 1'b1;
      tick();
      done();
      wait_tx(12, got, b, cyc);
      check("t6_no_spurious", got, 0);
      check("t6_busy_after", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
